// File: rtl/grid_cfg_loader.sv
// Command-driven configuration sequencer for the rotating-tile grid.
// Turns byte-wide host commands into scan, config-latch and loop-breaker controls, and reads back the scan chain.
module grid_cfg_loader #(
  parameter int LATCH_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       busy,
  input  logic       g_out_sc,
  output logic       g_se,
  output logic       g_sc,
  output logic [1:0] g_cfg,
  output logic       g_lb,
  output logic [1:0] g_lbc
);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, CYCLE} state_t;

  localparam logic [1:0] OP_SHIFT = 2'd0;
  localparam logic [1:0] OP_LATCH = 2'd1;
  localparam logic [1:0] OP_RUN   = 2'd2;
  localparam logic [1:0] OP_CYCLE = 2'd3;
  localparam logic [3:0] LAT_LAST = 4'(LATCH_CYCLES - 1);

  state_t     state, state_nx;
  logic [2:0] bit_cnt;
  logic [7:0] cyc_cnt, cyc_last;
  logic [3:0] lat_cnt;
  logic [7:0] sh_reg, cap_reg;
  logic [1:0] sel_r;
  logic       run_lb;
  logic [1:0] run_lbc;
  logic       accept;

  assign cmd_ready = (state == IDLE) & ~rst;
  assign busy      = (state != IDLE);
  assign accept    = cmd_valid & cmd_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) begin
        case (cmd_op)
          OP_SHIFT: state_nx = SHIFT;
          OP_LATCH: state_nx = LATCH;
          OP_CYCLE: state_nx = CYCLE;
          default:  state_nx = IDLE;
        endcase
      end
      SHIFT:   if (bit_cnt == 3'd7) state_nx = IDLE;
      LATCH:   if (lat_cnt == 4'd0) state_nx = IDLE;
      CYCLE:   if (cyc_cnt == cyc_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: the chain output is captured at the same edge that advances g_sc.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt  <= '0;
      cyc_cnt  <= '0;
      cyc_last <= '0;
      lat_cnt  <= '0;
      sh_reg   <= '0;
      cap_reg  <= '0;
      sel_r    <= '0;
      run_lb   <= 1'b1;
      run_lbc  <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          case (cmd_op)
            OP_SHIFT: begin
              sh_reg  <= cmd_data;
              bit_cnt <= '0;
            end
            OP_LATCH: begin
              sel_r   <= cmd_data[1:0];
              lat_cnt <= (cmd_data[1:0] == 2'd0) ? 4'd0 : LAT_LAST;
            end
            OP_RUN: begin
              run_lb  <= cmd_data[2];
              run_lbc <= cmd_data[1:0];
            end
            default: begin
              cyc_cnt  <= '0;
              cyc_last <= cmd_data - 8'd1;  // N==0 wraps to 255 -> 256 cycles
            end
          endcase
        end
        SHIFT: begin
          sh_reg  <= {1'b0, sh_reg[7:1]};
          cap_reg <= {g_out_sc, cap_reg[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            rd_data  <= {g_out_sc, cap_reg[7:1]};
            rd_valid <= 1'b1;
          end
        end
        LATCH:   lat_cnt <= lat_cnt - 4'd1;
        CYCLE:   cyc_cnt <= cyc_cnt + 8'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    g_se  = 1'b0;
    g_sc  = 1'b0;
    g_cfg = 2'd0;
    g_lb  = run_lb;
    g_lbc = run_lbc;
    case (state)
      SHIFT: begin
        g_se = 1'b1;
        g_sc = sh_reg[0];
      end
      LATCH: g_cfg = sel_r;
      CYCLE: begin
        g_lb  = 1'b1;
        g_lbc = cyc_cnt[1:0];
      end
      default: ;
    endcase
  end

endmodule
